// File: rtl/circulant_k_link.sv
// Buffered circulant interconnect: GENS_NUM generators, 2*GENS_NUM ports per router,
// and one LINK_DEPTH-entry valid/ready FIFO per destination port.
module circulant_k_link #(
  parameter int unsigned NODES_NUM = 8,
  parameter int unsigned GENS_NUM = 2,
  parameter int unsigned STEP_W = 16,
  parameter logic [GENS_NUM*STEP_W-1:0] STEPS = {16'd2, 16'd1},
  parameter int unsigned DATA_W = 37,
  parameter int unsigned LINK_DEPTH = 2
) (
  input  logic                                     clk,
  input  logic                                     a_rst_n,
  input  logic                                     flush,
  input  logic [NODES_NUM*2*GENS_NUM*DATA_W-1:0]   data_i,
  input  logic [NODES_NUM*2*GENS_NUM-1:0]          valid_i,
  output logic [NODES_NUM*2*GENS_NUM-1:0]          ready_o,
  output logic [NODES_NUM*2*GENS_NUM*DATA_W-1:0]   data_o,
  output logic [NODES_NUM*2*GENS_NUM-1:0]          valid_o,
  input  logic [NODES_NUM*2*GENS_NUM-1:0]          ready_i,
  output logic [NODES_NUM-1:0]                     busy_o
);

  localparam int unsigned P = 2 * GENS_NUM;
  localparam int unsigned L = NODES_NUM * P;
  localparam int unsigned PTR_W = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  if (LINK_DEPTH < 2 || (LINK_DEPTH & (LINK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("circulant_k_link: LINK_DEPTH must be a power of 2 and >= 2");
  end

  // Step g reduced modulo the ring size; evaluated only in constant context.
  function automatic int unsigned step_mod(int unsigned g);
    logic [STEP_W-1:0] s;
    s = STEPS[g*STEP_W +: STEP_W];
    return 32'(s) % NODES_NUM;
  endfunction

  // Unique source port feeding destination port d (inverse of the forward topology).
  function automatic int unsigned src_of(int unsigned d);
    int unsigned j, q, g;
    j = d / P;
    q = d % P;
    if (q < GENS_NUM) begin
      g = q;
      return ((j + step_mod(g)) % NODES_NUM) * P + (P - 1 - g);
    end
    g = P - 1 - q;
    return ((j + NODES_NUM - step_mod(g)) % NODES_NUM) * P + g;
  endfunction

  // Holds ready_o low from reset assertion until the first edge after release.
  logic live_q;
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) live_q <= 1'b0;
    else          live_q <= 1'b1;
  end

  logic [L-1:0] nonempty;

  for (genvar d = 0; d < L; d++) begin : g_link
    localparam int unsigned Src = src_of(d);

    logic [CNT_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [DATA_W-1:0] mem_q [LINK_DEPTH];
    logic              push, pop;

    assign ready_o[Src] = live_q && (cnt_q < CNT_W'(LINK_DEPTH));
    assign valid_o[d]   = (cnt_q != '0);
    assign data_o[d*DATA_W +: DATA_W] = mem_q[rd_q];
    assign nonempty[d]  = valid_o[d];

    assign push = valid_i[Src] && ready_o[Src];
    assign pop  = valid_o[d] && ready_i[d];

    always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
        cnt_q <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
      end else if (flush) begin
        cnt_q <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    // Storage needs no reset: entries are only observed behind valid_o.
    always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_q] <= data_i[Src*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    busy_o = '0;
    for (int n = 0; n < NODES_NUM; n++) busy_o[n] = |nonempty[n*P +: P];
  end

endmodule
